// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: HDR0 HDR1 CMD D3 D2 D1 D0 CSUM frames,
// with an ACK/NAK response byte sent back through the UART transmitter.
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  HDR0           = 8'h55,
    parameter logic [7:0]  HDR1           = 8'hAA,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rec_flag,
    output logic        rx_clr,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    input  logic        tx_idle,
    output logic [7:0]  cmd_code,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        GOT_H0,
        GET_CMD,
        GET_DATA,
        GET_CSUM,
        SEND,
        WAIT_TX
    } state_t;

    localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    logic          arm;
    logic [1:0]    idx;
    logic [7:0]    cmd_shadow;
    logic [31:0]   data_shadow;
    logic [7:0]    csum;
    logic [7:0]    resp;
    logic [GW-1:0] gap;

    logic accept;
    logic in_frame;
    logic timed_out;

    // The receiver flag is level-held, so arm blocks re-taking the same byte
    // until the flag has been observed low after rx_clr.
    assign accept    = rx_rec_flag && arm;
    assign in_frame  = state inside {GOT_H0, GET_CMD, GET_DATA, GET_CSUM};
    assign timed_out = in_frame && !accept && (gap == GW'(TIMEOUT_CYCLES - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            arm         <= 1'b1;
            idx         <= '0;
            cmd_shadow  <= '0;
            data_shadow <= '0;
            csum        <= '0;
            resp        <= '0;
            gap         <= '0;
            rx_clr      <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            cmd_code    <= '0;
            cmd_data    <= '0;
            cmd_valid   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_clr    <= accept;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            tx_start  <= 1'b0;

            if (accept)
                arm <= 1'b0;
            else if (!rx_rec_flag)
                arm <= 1'b1;

            if (!in_frame || accept)
                gap <= '0;
            else
                gap <= gap + GW'(1);

            if (timed_out) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && rx_data == HDR0)
                            state <= GOT_H0;
                    end
                    GOT_H0: begin
                        if (accept) begin
                            if (rx_data == HDR1)
                                state <= GET_CMD;
                            else if (rx_data != HDR0)
                                state <= IDLE;
                        end
                    end
                    GET_CMD: begin
                        if (accept) begin
                            cmd_shadow <= rx_data;
                            csum       <= rx_data;
                            idx        <= '0;
                            state      <= GET_DATA;
                        end
                    end
                    GET_DATA: begin
                        if (accept) begin
                            data_shadow <= {data_shadow[23:0], rx_data};
                            csum        <= csum + rx_data;
                            idx         <= idx + 2'd1;
                            if (idx == 2'd3)
                                state <= GET_CSUM;
                        end
                    end
                    GET_CSUM: begin
                        if (accept) begin
                            if (rx_data == csum) begin
                                cmd_code  <= cmd_shadow;
                                cmd_data  <= data_shadow;
                                cmd_valid <= 1'b1;
                                resp      <= ACK_BYTE;
                            end else begin
                                frame_err <= 1'b1;
                                resp      <= NAK_BYTE;
                            end
                            state <= SEND;
                        end
                    end
                    SEND: begin
                        if (tx_idle) begin
                            tx_data  <= resp;
                            tx_start <= 1'b1;
                            state    <= WAIT_TX;
                        end
                    end
                    WAIT_TX: begin
                        if (tx_done)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame table plus hand-written corner sequences,
// with receiver/transmitter models and a scoreboard of expected events.
module tb_uart_cmd_parser;

    localparam int unsigned TMO     = 200;
    localparam logic [7:0]  ACK     = 8'h06;
    localparam logic [7:0]  NAK     = 8'h15;
    localparam int          TX_BUSY = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rec_flag;
    logic        rx_clr;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        tx_idle;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        frame_err;
    logic        busy;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(TMO),
        .HDR0(8'h55),
        .HDR1(8'hAA),
        .ACK_BYTE(ACK),
        .NAK_BYTE(NAK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_rec_flag(rx_rec_flag),
        .rx_clr(rx_clr),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_done(tx_done),
        .tx_idle(tx_idle),
        .cmd_code(cmd_code),
        .cmd_data(cmd_data),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    typedef struct {
        logic [63:0] frame;
        logic        ok;
        logic [7:0]  code;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [7:0]  code;
        logic [31:0] data;
    } cmd_t;

    cmd_t       exp_cmd_q[$];
    logic [7:0] exp_tx_q[$];
    int         exp_err_q[$];

    int errors = 0;
    int checks = 0;

    logic [7:0]  last_code = '0;
    logic [31:0] last_data = '0;
    int          tx_count = 0;
    int          sending_cnt = 0;
    logic [7:0]  held;
    bit          hold_busy = 1'b0;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        cmd_t c;
        logic [7:0] t;
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("cmd_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    c = exp_cmd_q.pop_front();
                    chk("cmd_code", 32'(cmd_code), 32'(c.code));
                    chk("cmd_data", cmd_data, c.data);
                    // rx_clr marks the cycle after the CSUM accept
                    chk("cmd_valid_latency", 32'(rx_clr), 32'd1);
                end
            end
            if (frame_err) begin
                if (exp_err_q.size() == 0)
                    chk("frame_err_unexpected", 32'd1, 32'd0);
                else
                    chk("frame_err_pending", 32'(exp_err_q.pop_front()), 32'd1);
            end
            if (tx_start) begin
                tx_count++;
                if (exp_tx_q.size() == 0) begin
                    chk("tx_start_unexpected", 32'd1, 32'd0);
                end else begin
                    t = exp_tx_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(t));
                end
            end
        end
    endtask

    task automatic tx_model();
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (sending_cnt > 0) begin
                sending_cnt--;
                if (sending_cnt == 0) begin
                    chk("tx_data_stable", 32'(tx_data), 32'(held));
                    tx_done = 1'b1;
                end
            end else if (tx_start) begin
                held        = tx_data;
                sending_cnt = TX_BUSY;
            end
            tx_idle = !hold_busy && sending_cnt == 0 && !tx_start;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        rx_data     = b;
        rx_rec_flag = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (rx_clr) seen = 1'b1;
        end
        chk("rx_clr_seen", 32'(seen), 32'd1);
        rx_rec_flag = 1'b0;
        @(negedge clk);
        chk("rx_clr_single", 32'(rx_clr), 32'd0);
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 0; i < 8; i++)
            send_byte(f[63-8*i -: 8]);
    endtask

    task automatic expect_frame(input logic ok, input logic [7:0] code, input logic [31:0] data);
        cmd_t c;
        if (ok) begin
            c.code = code;
            c.data = data;
            exp_cmd_q.push_back(c);
            exp_tx_q.push_back(ACK);
            last_code = code;
            last_data = data;
        end else begin
            exp_err_q.push_back(1);
            exp_tx_q.push_back(NAK);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (!busy && sending_cnt == 0) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_clr"}, 32'(rx_clr), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_cmd_code"}, 32'(cmd_code), 32'd0);
        chk({tag, "_cmd_data"}, cmd_data, 32'd0);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int tc0;
        bit seen;

        vecs[0] = '{64'h55AA0112345678_15, 1'b1, 8'h01, 32'h12345678};
        vecs[1] = '{64'h55AA0112345678_00, 1'b0, 8'h00, 32'h0};
        vecs[2] = '{64'h55AA7FFFFFFFFF_7B, 1'b1, 8'h7F, 32'hFFFFFFFF};
        vecs[3] = '{64'h55AA0000000000_00, 1'b1, 8'h00, 32'h00000000};
        vecs[4] = '{64'h55AAA501020304_AF, 1'b1, 8'hA5, 32'h01020304};
        vecs[5] = '{64'h55AAA501020304_B0, 1'b0, 8'h00, 32'h0};

        rst         = 1'b1;
        rx_data     = '0;
        rx_rec_flag = 1'b0;
        tx_done     = 1'b0;
        tx_idle     = 1'b1;
        fork
            monitor();
            tx_model();
        join_none
        repeat (3) @(negedge clk);
        chk_reset_outputs("init");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            expect_frame(vecs[i].ok, vecs[i].code, vecs[i].data);
            send_frame(vecs[i].frame);
            wait_idle("frame_done");
            chk("hold_code", 32'(cmd_code), 32'(last_code));
            chk("hold_data", cmd_data, last_data);
        end

        // Leading garbage and repeated HDR0 before a valid frame
        expect_frame(1'b1, 8'h02, 32'h00000001);
        send_byte(8'h00);
        send_byte(8'h55);
        send_byte(8'h55);
        send_frame(64'hAA02000000010300);
        wait_idle("resync_done");
        chk("resync_code", 32'(cmd_code), 32'h02);
        chk("resync_data", cmd_data, 32'h1);
        // Final 8'h00 above lands in IDLE and must be discarded
        chk("resync_idle", 32'(busy), 32'd0);

        // Inter-byte timeout mid-frame
        exp_err_q.push_back(1);
        tc0 = tx_count;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h01);
        chk("tmo_busy_before", 32'(busy), 32'd1);
        repeat (TMO + 60) @(negedge clk);
        chk("tmo_idle", 32'(busy), 32'd0);
        chk("tmo_no_tx", 32'(tx_count), 32'(tc0));
        expect_frame(1'b1, 8'h01, 32'h12345678);
        send_frame(64'h55AA011234567815);
        wait_idle("tmo_recover");

        // Transmitter not idle after CSUM, then a stray byte during WAIT_TX
        hold_busy = 1'b1;
        expect_frame(1'b1, 8'h10, 32'h0000002A);
        send_frame(64'h55AA100000002A3A);
        tc0 = tx_count;
        repeat (50) @(negedge clk);
        chk("txidle_no_start", 32'(tx_count), 32'(tc0));
        chk("txidle_busy", 32'(busy), 32'd1);
        hold_busy = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (tx_count != tc0) seen = 1'b1;
        end
        chk("txidle_start_seen", 32'(seen), 32'd1);
        send_byte(8'h55);
        chk("stray_busy", 32'(busy), 32'd1);
        wait_idle("stray_done");
        chk("stray_code", 32'(cmd_code), 32'h10);

        // Reset after D1
        for (int i = 0; i < 6; i++)
            send_byte(vecs[0].frame[63-8*i -: 8]);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        last_code = '0;
        last_data = '0;
        expect_frame(1'b1, 8'hA5, 32'h01020304);
        send_frame(vecs[4].frame);
        wait_idle("post_reset_done");
        chk("post_reset_code", 32'(cmd_code), 32'hA5);

        repeat (5) @(negedge clk);
        chk("sb_cmd_empty", 32'(exp_cmd_q.size()), 32'd0);
        chk("sb_tx_empty", 32'(exp_tx_q.size()), 32'd0);
        chk("sb_err_empty", 32'(exp_err_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
